antirrebote_pulso: RTL and testbench

Push-button front end for the `conta_*_ers` counter family. It synchronizes and debounces two raw buttons, `btn_up` and `btn_down`, and converts each accepted press into a one-cycle `enable` pulse plus a registered `up_down` direction. Both outputs wire directly to the `enable` and `up_down` inputs of `conta_up_down_ers` (or to `enable` alone on the other counters). It sits directly upstream of the counter, on the same clock.

---
 rtl/antirrebote_pkg.sv | 22 ++
 rtl/sincronizador_2ff.sv | 26 ++
 rtl/antirrebote_pulso.sv | 155 +++++++++++++++
 tb/tb_antirrebote_pulso.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/antirrebote_pkg.sv
// Shared types and constants for the antirrebote_pulso push-button front end.
package antirrebote_pkg;

  // Debounce FSM states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE          = 2'd0,
    CHECK_PRESS   = 2'd1,
    HELD          = 2'd2,
    CHECK_RELEASE = 2'd3
  } state_t;

  // Direction driven on up_down after reset (count up).
  localparam logic DIR_UP = 1'b1;

  // Counter width: clog2 of the larger of the two periods, never below 1 bit.
  function automatic int cnt_width(input int deb, input int rep);
    int m;
    m = (deb > rep) ? deb : rep;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// 1-bit two-flop synchronizer for a raw asynchronous input; synchronous reset
// clears both stages.
module sincronizador_2ff (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/antirrebote_pulso.sv
// Synchronizes and debounces two raw buttons (up / down) and turns each
// accepted press into a one-cycle enable pulse plus a registered direction.
// Optional feature macro: ANTIRREBOTE_AUTOREPEAT_EN -- when defined, a held
// button repeats its pulse every REP_CYCLES cycles.
module antirrebote_pulso
  import antirrebote_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int REP_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic enable,
  output logic up_down
);

  localparam int CW = cnt_width(DEB_CYCLES, REP_CYCLES);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REP_CYCLES - 1);
`endif

  logic w_up_s;
  logic w_dn_s;

  sincronizador_2ff u_sync_up (
    .clk     (clk),
    .reset   (reset),
    .i_async (btn_up),
    .o_sync  (w_up_s)
  );

  sincronizador_2ff u_sync_dn (
    .clk     (clk),
    .reset   (reset),
    .i_async (btn_down),
    .o_sync  (w_dn_s)
  );

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_dir;
  logic            w_dir_next;
  logic            r_enable;
  logic            w_enable_next;
  logic            r_up_down;
  logic            w_up_down_next;

  // The button being debounced and the one that is not, relative to r_dir.
  logic            w_latched;
  logic            w_other;
  logic [CW-1:0]   w_cnt_inc;

  assign w_latched = r_dir ? w_up_s : w_dn_s;
  assign w_other   = r_dir ? w_dn_s : w_up_s;
  // Saturating increment: the counter holds at all-ones rather than wrapping.
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

  // State, counter and output registers; reset overrides any pending pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dir     <= DIR_UP;
      r_enable  <= 1'b0;
      r_up_down <= DIR_UP;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_dir     <= w_dir_next;
      r_enable  <= w_enable_next;
      r_up_down <= w_up_down_next;
    end
  end

  // Next-state, counter and pulse decisions for the debounce FSM.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_dir_next     = r_dir;
    w_enable_next  = 1'b0;
    w_up_down_next = r_up_down;

    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        // Only a single pressed button starts a debounce; both or none wait.
        if (w_up_s ^ w_dn_s) begin
          w_dir_next   = w_up_s;
          w_state_next = CHECK_PRESS;
        end
      end

      CHECK_PRESS: begin
        if (!w_latched || w_other) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next   = HELD;
          w_cnt_next     = '0;
          w_enable_next  = 1'b1;
          w_up_down_next = r_dir;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      HELD: begin
        if (!w_latched) begin
          w_state_next = CHECK_RELEASE;
          w_cnt_next   = '0;
        end else begin
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
          if (r_cnt == REP_LAST) begin
            w_cnt_next     = '0;
            w_enable_next  = 1'b1;
            w_up_down_next = r_dir;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
`else
          w_cnt_next = '0;
`endif
        end
      end

      CHECK_RELEASE: begin
        // A bounce back to pressed resumes the hold without a new pulse.
        if (w_latched) begin
          w_state_next = HELD;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end

      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign enable  = r_enable;
  assign up_down = r_up_down;

endmodule

// File: tb/tb_antirrebote_pulso.sv
// Self-checking bench for antirrebote_pulso (DEB_CYCLES=4, REP_CYCLES=8).
// Honours ANTIRREBOTE_AUTOREPEAT_EN when the design is built with it.
module tb_antirrebote_pulso;

  localparam int DEB = 4;
  localparam int REP = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0;
  logic btn_down = 1'b0;
  logic enable;
  logic up_down;

  antirrebote_pulso #(.DEB_CYCLES(DEB), .REP_CYCLES(REP)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .enable   (enable),
    .up_down  (up_down)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Per-edge stimulus (index i = i-th rising edge of a play run) and the
  // expected pulse list derived from the button-level rules.
  bit up_q[$];
  bit dn_q[$];
  bit rst_q[$];
  int p_edge[$];
  bit p_dir[$];

  typedef struct {
    int up_start;
    int up_len;
    int dn_start;
    int dn_len;
    int n;
    int pa;
    int pb;
    bit pdir;
  } vec_t;

  vec_t vecs[8];

  task automatic check_bit(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %b want %b", name, idx, act, exp);
    end
  endtask

  task automatic clear_seq();
    up_q.delete();
    dn_q.delete();
    rst_q.delete();
    p_edge.delete();
    p_dir.delete();
  endtask

  task automatic push(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      up_q.push_back(u);
      dn_q.push_back(d);
      rst_q.push_back(1'b0);
    end
  endtask

  task automatic push_rst(input bit u, input bit d, input int n);
    for (int i = 0; i < n; i++) begin
      up_q.push_back(u);
      dn_q.push_back(d);
      rst_q.push_back(1'b1);
    end
  endtask

  // Drive one button (d=1 up, d=0 down) at a level for n cycles.
  task automatic push_btn(input bit d, input bit level, input int n);
    push(level & d, level & ~d, n);
  endtask

  task automatic add_pulse(input int e, input bit d);
    p_edge.push_back(e);
    p_dir.push_back(d);
  endtask

  task automatic do_reset(input int n, input bit u, input bit d);
    for (int i = 0; i < n; i++) begin
      reset = 1'b1;
      btn_up = u;
      btn_down = d;
      @(posedge clk);
      @(negedge clk);
      check_bit("reset_enable", i, enable, 1'b0);
      check_bit("reset_up_down", i, up_down, 1'b1);
    end
  endtask

  // Apply the queued stimulus, one edge per entry, and compare every cycle.
  task automatic play(input string name);
    bit exp_en;
    bit exp_ud;
    exp_ud = 1'b1;
    for (int i = 0; i < up_q.size(); i++) begin
      reset = rst_q[i];
      btn_up = up_q[i];
      btn_down = dn_q[i];
      @(posedge clk);
      @(negedge clk);
      exp_en = 1'b0;
      if (rst_q[i]) begin
        exp_ud = 1'b1;
      end else begin
        for (int j = 0; j < p_edge.size(); j++) begin
          if (p_edge[j] == i) begin
            exp_en = 1'b1;
            exp_ud = p_dir[j];
          end
        end
      end
      check_bit({name, "_enable"}, i, enable, exp_en);
      check_bit({name, "_up_down"}, i, up_down, exp_ud);
    end
  endtask

  // Random episodes: pure noise, a (possibly bouncy) press, or both buttons.
  task automatic gen_random(input int n_ep);
    int kind;
    bit d;
    int nb;
    int t;
    int h;
    int bl;
`ifndef ANTIRREBOTE_AUTOREPEAT_EN
    int m;
`endif
    push(0, 0, DEB + 3);
    for (int ep = 0; ep < n_ep; ep++) begin
      kind = $urandom_range(0, 2);
      d = 1'($urandom_range(0, 1));
      case (kind)
        0: begin
          // Highs never last DEB+1 synced samples: nothing may be accepted.
          nb = $urandom_range(1, 4);
          for (int b = 0; b < nb; b++) begin
            push_btn(d, 1'b1, $urandom_range(1, DEB));
            push_btn(d, 1'b0, $urandom_range(1, 3));
          end
          push(0, 0, DEB + 3);
        end
        1: begin
          nb = $urandom_range(0, 2);
          for (int b = 0; b < nb; b++) begin
            push_btn(d, 1'b1, $urandom_range(1, DEB));
            push_btn(d, 1'b0, $urandom_range(1, 3));
          end
          t = up_q.size();
          h = $urandom_range(DEB + 6, DEB + 16);
          push_btn(d, 1'b1, h);
          // Short blip on the other button once the press is already held.
          if ($urandom_range(0, 1) == 1) begin
            bl = $urandom_range(1, 3);
            for (int i = 0; i < bl; i++) begin
              if (d) dn_q[t + DEB + 2 + i] = 1'b1;
              else   up_q[t + DEB + 2 + i] = 1'b1;
            end
          end
          // Two sync stages plus DEB+1 stable samples.
          add_pulse(t + 2 + DEB, d);
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
          for (int n = 1; DEB + n * REP <= h - 1; n++) add_pulse(t + 2 + DEB + n * REP, d);
`else
          // Release bounces shorter than DEB+1 samples keep the press held.
          m = $urandom_range(0, 2);
          for (int b = 0; b < m; b++) begin
            push_btn(d, 1'b0, $urandom_range(1, DEB));
            push_btn(d, 1'b1, $urandom_range(1, 6));
          end
`endif
          push(0, 0, DEB + 3);
        end
        default: begin
          push(1, 1, $urandom_range(1, 20));
          push(0, 0, DEB + 3);
        end
      endcase
    end
    push(0, 0, 4);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // {up_start, up_len, dn_start, dn_len, n, first pulse, second pulse, dir}
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    vecs[0] = '{0, 20, -1, 0, 30, 6, 14, 1'b1};
`else
    vecs[0] = '{0, 20, -1, 0, 30, 6, -1, 1'b1};
`endif
    vecs[1] = '{0, 20, 0, 20, 30, -1, -1, 1'b1};
    vecs[2] = '{-1, 0, 3, 10, 25, 9, -1, 1'b0};
    vecs[3] = '{0, DEB + 1, -1, 0, 20, 6, -1, 1'b1};
    vecs[4] = '{0, DEB, -1, 0, 20, -1, -1, 1'b1};
    vecs[5] = '{0, 12, 6, 3, 25, 6, -1, 1'b1};
    vecs[6] = '{2, 2, 0, 10, 25, 10, -1, 1'b0};
    vecs[7] = '{-1, 0, 0, DEB + 1, 20, 6, -1, 1'b0};

    // Button held through reset: debounced from scratch after release.
    do_reset(3, 1'b1, 1'b0);
    clear_seq();
    push(1, 0, 20);
    add_pulse(6, 1'b1);
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    add_pulse(14, 1'b1);
`endif
    play("held_reset");

    for (int v = 0; v < 8; v++) begin
      do_reset(2, 1'b0, 1'b0);
      clear_seq();
      for (int i = 0; i < vecs[v].n; i++) begin
        push((i >= vecs[v].up_start) && (i < vecs[v].up_start + vecs[v].up_len) && (vecs[v].up_start >= 0),
             (i >= vecs[v].dn_start) && (i < vecs[v].dn_start + vecs[v].dn_len) && (vecs[v].dn_start >= 0),
             1);
      end
      if (vecs[v].pa >= 0) add_pulse(vecs[v].pa, vecs[v].pdir);
      if (vecs[v].pb >= 0) add_pulse(vecs[v].pb, vecs[v].pdir);
      play($sformatf("vec%0d", v));
    end

    // Down bounce: high 2, low 1, high 12; pulse 6 edges after the last rise.
    do_reset(2, 1'b0, 1'b0);
    clear_seq();
    push(0, 1, 2);
    push(0, 0, 1);
    push(0, 1, 12);
    push(0, 0, 8);
    add_pulse(9, 1'b0);
    play("bounce_down");

    // Short drop while held gives no pulse; a full release then a press does.
    do_reset(2, 1'b0, 1'b0);
    clear_seq();
    push(1, 0, 7);
    push(0, 0, 2);
    push(1, 0, 10);
    push(0, 0, 6);
    push(1, 0, 10);
    push(0, 0, 8);
    add_pulse(6, 1'b1);
    add_pulse(31, 1'b1);
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    add_pulse(19, 1'b1);
`endif
    play("drop_rehold");

    // Long down hold: one pulse, or a pulse every REP cycles with repeat.
    do_reset(2, 1'b0, 1'b0);
    clear_seq();
    push(0, 1, 40);
    push(0, 0, 8);
    add_pulse(6, 1'b0);
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    add_pulse(14, 1'b0);
    add_pulse(22, 1'b0);
    add_pulse(30, 1'b0);
    add_pulse(38, 1'b0);
`endif
    play("hold_down");

    // Down press sets up_down=0; reset during the next up debounce aborts
    // its pulse and restores up_down=1; the still-held button then pulses.
    do_reset(2, 1'b0, 1'b0);
    clear_seq();
    push(0, 1, 12);
    push(0, 0, DEB + 3);
    push(1, 0, 4);
    push_rst(1, 0, 2);
    push(1, 0, 20);
    push(0, 0, 8);
    add_pulse(6, 1'b0);
    add_pulse(31, 1'b1);
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    add_pulse(39, 1'b1);
`endif
    play("mid_reset");

    // Randomized episodes against the button-level model.
    do_reset(2, 1'b0, 1'b0);
    clear_seq();
    gen_random(40);
    play("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
